// File: rtl/matrix_line_fetcher.sv
// Fetches a strided tile of lines from the line ROM and streams them downstream.
// A 2-entry row FIFO decouples ROM returns from the consumer.
module matrix_line_fetcher #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LINE_LEN   = 16,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned MAX_ROWS   = 16,
    localparam int unsigned AW = $clog2(MEM_DEPTH),
    localparam int unsigned RW = $clog2(MAX_ROWS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW-1:0]         stride,
    input  logic [RW-1:0]         num_rows,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_err,
    output logic                  fetch,
    output logic                  addr_use_ext,
    output logic [AW-1:0]         addr_ext,
    input  logic                  ready,
    input  logic                  line_valid,
    input  logic [AW-1:0]         used_addr,
    input  logic [DATA_WIDTH-1:0] line_in [0:LINE_LEN-1],
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [RW-1:0]         row_idx,
    output logic [DATA_WIDTH-1:0] row_data [0:LINE_LEN-1]
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

    state_e          state_q;
    logic [AW-1:0]   next_addr_q;
    logic [AW-1:0]   cur_addr_q;
    logic [AW-1:0]   stride_q;
    logic [RW-1:0]   num_rows_q;
    logic [RW-1:0]   issued_q;
    logic            fetch_q;
    logic            busy_q;
    logic            done_q;
    logic            addr_err_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [0:1][0:LINE_LEN-1];
    logic [RW-1:0]         fifo_idx_q  [0:1];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  push;
    logic                  pop;
    logic                  fetch_ok;

    assign push     = (state_q == StWait) && line_valid;
    assign pop      = (count_q != 2'd0) && row_ready;
    assign count_d  = count_q + {1'b0, push} - {1'b0, pop};
    // fetch is decided from the post-update count so a free slot is guaranteed at return
    assign fetch_ok = (count_d < 2'd2);

    assign busy         = busy_q;
    assign done         = done_q;
    assign addr_err     = addr_err_q;
    assign fetch        = fetch_q;
    assign addr_use_ext = 1'b1;
    assign addr_ext     = next_addr_q;
    assign row_valid    = (count_q != 2'd0);
    assign row_idx      = fifo_idx_q[rd_ptr_q];

    always_comb begin
        for (int j = 0; j < int'(LINE_LEN); j++) begin
            row_data[j] = fifo_data_q[rd_ptr_q][j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_idx_q[i] <= '0;
                for (int j = 0; j < int'(LINE_LEN); j++) begin
                    fifo_data_q[i][j] <= '0;
                end
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                for (int j = 0; j < int'(LINE_LEN); j++) begin
                    fifo_data_q[wr_ptr_q][j] <= line_in[j];
                end
                fifo_idx_q[wr_ptr_q] <= issued_q - RW'(1);
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            next_addr_q <= '0;
            cur_addr_q  <= '0;
            stride_q    <= '0;
            num_rows_q  <= '0;
            issued_q    <= '0;
            fetch_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_err_q <= 1'b0;
                        if (num_rows == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            num_rows_q  <= num_rows;
                            stride_q    <= stride;
                            next_addr_q <= base_addr;
                            issued_q    <= '0;
                            busy_q      <= 1'b1;
                            fetch_q     <= 1'b1;
                            state_q     <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (fetch_q && ready) begin
                        issued_q    <= issued_q + RW'(1);
                        cur_addr_q  <= next_addr_q;
                        next_addr_q <= next_addr_q + stride_q;
                        fetch_q     <= 1'b0;
                        state_q     <= StWait;
                    end else begin
                        fetch_q <= fetch_ok;
                    end
                end
                StWait: begin
                    if (line_valid) begin
                        if (used_addr != cur_addr_q) begin
                            addr_err_q <= 1'b1;
                        end
                        if (issued_q == num_rows_q) begin
                            state_q <= StDrain;
                        end else begin
                            fetch_q <= fetch_ok;
                            state_q <= StIssue;
                        end
                    end
                end
                StDrain: begin
                    if (count_d == 2'd0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_line_fetcher.sv
// Randomized bench for matrix_line_fetcher: a reactive ROM model plus a
// queue-based reference of the rows each command must produce.
module tb_matrix_line_fetcher;

    localparam int DW = 16;
    localparam int LL = 16;
    localparam int MD = 256;
    localparam int AW = 8;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic [RW-1:0] num_rows;
    logic          busy;
    logic          done;
    logic          addr_err;
    logic          fetch;
    logic          addr_use_ext;
    logic [AW-1:0] addr_ext;
    logic          ready;
    logic          line_valid;
    logic [AW-1:0] used_addr;
    logic [DW-1:0] line_in [0:LL-1];
    logic          row_valid;
    logic          row_ready;
    logic [RW-1:0] row_idx;
    logic [DW-1:0] row_data [0:LL-1];

    matrix_line_fetcher dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .stride       (stride),
        .num_rows     (num_rows),
        .busy         (busy),
        .done         (done),
        .addr_err     (addr_err),
        .fetch        (fetch),
        .addr_use_ext (addr_use_ext),
        .addr_ext     (addr_ext),
        .ready        (ready),
        .line_valid   (line_valid),
        .used_addr    (used_addr),
        .line_in      (line_in),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_idx      (row_idx),
        .row_data     (row_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [DW-1:0] rom [0:MD-1];

    logic [255:0] exp_data_q [$];
    int           exp_idx_q  [$];
    int           exp_addr_q [$];

    int done_cnt = 0;
    int last_pop_cyc = 0;
    bit last_cmd_nz = 0;
    int acc_cnt = 0;
    int corrupt_row = -1;
    int max_stall = 0;
    int stall_left = 0;
    bit rr_random = 0;
    bit spur = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] packed_head();
        logic [255:0] p = '0;
        for (int j = 0; j < LL; j++) p[j*DW +: DW] = row_data[j];
        return p;
    endfunction

    function automatic logic [255:0] model_line(input int a);
        logic [255:0] p = '0;
        for (int j = 0; j < LL; j++) p[j*DW +: DW] = rom[(a + j) % MD];
        return p;
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_fetch"}, fetch, 0);
        check_eq({tag, "_addr_ext"}, addr_ext, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_row_valid"}, row_valid, 0);
        check_eq({tag, "_row_idx"}, row_idx, 0);
        check_eq({tag, "_row_data"}, packed_head(), 0);
        check_eq({tag, "_addr_err"}, addr_err, 0);
        check_eq({tag, "_use_ext"}, addr_use_ext, 1);
    endtask

    // Drive one start strobe; when it should be accepted, load the reference rows.
    task automatic start_cmd(input int base, input int strd, input int n, input bit accept);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(base);
        stride    = AW'(strd);
        num_rows  = RW'(n);
        if (accept) begin
            acc_cnt     = 0;
            last_cmd_nz = (n != 0);
            for (int k = 0; k < n; k++) begin
                int a;
                a = (base + k * strd) % MD;
                exp_addr_q.push_back(a);
                exp_idx_q.push_back(k);
                exp_data_q.push_back(model_line(a));
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (accept) begin
            @(negedge clk);
            check_eq("c1_busy", busy, (n != 0));
            check_eq("c1_done", done, (n == 0));
            check_eq("c1_fetch", fetch, (n != 0));
            check_eq("c1_addr_err", addr_err, 0);
        end
    endtask

    task automatic wait_done(input int d0, input int budget);
        int i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        repeat (2) @(negedge clk);
        #1;
        check_eq("done_count", done_cnt - d0, 1);
        check_eq("rows_left", exp_data_q.size(), 0);
        check_eq("fetches_left", exp_addr_q.size(), 0);
    endtask

    // Output monitor: row scoreboard, done timing, fetch hold under stall.
    initial begin
        bit            prev_stall = 0;
        logic [AW-1:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (row_valid && row_ready && !rst) begin
                if (exp_data_q.size() == 0) begin
                    check_eq("unexpected_row", 1, 0);
                end else begin
                    check_eq("row_idx", row_idx, exp_idx_q.pop_front());
                    check_eq("row_data", packed_head(), exp_data_q.pop_front());
                end
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check_eq("done_busy", busy, 0);
                if (last_cmd_nz) check_eq("done_after_pop", cyc - last_pop_cyc, 1);
            end
            if (prev_stall) begin
                check_eq("fetch_hold", fetch, 1);
                check_eq("addr_hold", addr_ext, prev_addr);
            end
            prev_stall = fetch && !ready && !rst;
            prev_addr  = addr_ext;
        end
    end

    // Reactive ROM: one-cycle return latency, random ready stalls after each accept.
    initial begin
        bit            acc;
        bit            fseen;
        logic [AW-1:0] acc_a;
        ready      = 1'b1;
        line_valid = 1'b0;
        used_addr  = '0;
        for (int j = 0; j < LL; j++) line_in[j] = '0;
        forever begin
            @(negedge clk);
            acc   = fetch && ready;
            fseen = fetch;
            acc_a = addr_ext;
            @(posedge clk);
            #1;
            if (acc) begin
                if (exp_addr_q.size() == 0) check_eq("unexpected_fetch", 1, 0);
                else check_eq("fetch_addr", acc_a, exp_addr_q.pop_front());
                acc_cnt++;
                line_valid = 1'b1;
                used_addr  = (acc_cnt - 1 == corrupt_row) ? (acc_a ^ 8'h01) : acc_a;
                for (int j = 0; j < LL; j++) line_in[j] = rom[(acc_a + j) % MD];
                stall_left = $urandom_range(0, max_stall);
            end else begin
                line_valid = spur;
                if (spur) used_addr = 8'h55;
                spur = 0;
                if (stall_left != 0 && fseen) stall_left--;
            end
            ready = (stall_left == 0);
            if (rr_random) row_ready = $urandom_range(0, 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        stride    = '0;
        num_rows  = '0;
        row_ready = 1'b1;
        for (int k = 0; k < MD; k++) rom[k] = DW'(k);
        #12;
        check_reset("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic fetch with latency checks
        d0 = done_cnt;
        start_cmd(8'h10, 16, 3, 1);
        @(negedge clk);
        check_eq("c2_row_valid", row_valid, 0);
        @(negedge clk);
        check_eq("c3_row_valid", row_valid, 1);
        check_eq("c3_fetch", fetch, 1);
        wait_done(d0, 200);
        check_eq("basic_addr_err", addr_err, 0);

        // line_valid while idle must be ignored
        spur = 1;
        repeat (3) @(negedge clk);
        check_eq("spur_row_valid", row_valid, 0);
        check_eq("spur_addr_err", addr_err, 0);

        // Wrap-around
        d0 = done_cnt;
        start_cmd(8'hF8, 16, 2, 1);
        wait_done(d0, 200);

        // Backpressure
        row_ready = 1'b0;
        d0 = done_cnt;
        start_cmd(8'h20, 7, 5, 1);
        repeat (30) @(negedge clk);
        check_eq("bp_fetch", fetch, 0);
        check_eq("bp_busy", busy, 1);
        check_eq("bp_row_valid", row_valid, 1);
        check_eq("bp_rows_pending", exp_data_q.size(), 5);
        @(posedge clk);
        #1;
        row_ready = 1'b1;
        wait_done(d0, 200);

        // Random stall, clean then with a corrupted used_addr on row 4
        max_stall = 5;
        d0 = done_cnt;
        start_cmd($urandom_range(0, 255), 3, 8, 1);
        wait_done(d0, 500);
        check_eq("stall_addr_err", addr_err, 0);
        corrupt_row = 4;
        d0 = done_cnt;
        start_cmd($urandom_range(0, 255), 3, 8, 1);
        wait_done(d0, 500);
        check_eq("corrupt_addr_err", addr_err, 1);
        repeat (5) @(negedge clk);
        check_eq("corrupt_sticky", addr_err, 1);
        corrupt_row = -1;
        max_stall = 0;

        // Zero rows also clears the sticky error
        d0 = done_cnt;
        start_cmd(8'h33, 1, 0, 1);
        wait_done(d0, 20);

        // Start while busy has no effect
        d0 = done_cnt;
        start_cmd(8'h40, 5, 4, 1);
        repeat (2) @(posedge clk);
        start_cmd(8'h80, 1, 2, 0);
        wait_done(d0, 200);

        // Random commands with random backpressure and stalls
        for (int k = 0; k < MD; k++) rom[k] = DW'($urandom);
        rr_random = 1;
        for (int r = 0; r < 6; r++) begin
            max_stall = $urandom_range(0, 3);
            d0 = done_cnt;
            start_cmd($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 16), 1);
            wait_done(d0, 3000);
        end
        rr_random = 0;
        max_stall = 0;
        @(posedge clk);
        #1;
        row_ready = 1'b1;

        // Mid-operation reset right after the row-1 fetch is accepted
        corrupt_row = 0;
        start_cmd(8'h60, 16, 4, 1);
        for (int i = 0; i < 50 && acc_cnt < 2; i++) begin
            @(posedge clk);
            #2;
        end
        check_eq("mid_acc_cnt", acc_cnt, 2);
        check_eq("mid_pre_addr_err", addr_err, 1);
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        #1;
        rst = 1'b0;
        corrupt_row = -1;
        exp_data_q.delete();
        exp_idx_q.delete();
        exp_addr_q.delete();
        last_cmd_nz = 0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("late_lv_row_valid", row_valid, 0);
        check_eq("late_lv_busy", busy, 0);
        d0 = done_cnt;
        start_cmd(8'h05, 9, 3, 1);
        wait_done(d0, 200);
        check_eq("post_rst_addr_err", addr_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_line_fetcher.md
# matrix_line_fetcher

Requester-side controller for the line-fetch ROM interface. On a `start` command it fetches `num_rows` lines from the line ROM, starting at `base_addr` and advancing by `stride` words per row. Returned lines go into a 2-entry row FIFO, which presents them downstream as a valid/ready row stream with a row index. It sits between the operand memories and the matrix-multiply datapath, and loads one operand tile per command.

## Interface
- `DATA_WIDTH`, 16: word width.
- `LINE_LEN`, 16: words per line/row.
- `MEM_DEPTH`, 256: ROM depth in words; must be a power of two. `AW` = $clog2(MEM_DEPTH) is derived.
- `MAX_ROWS`, 16: maximum rows per command. `RW` = $clog2(MAX_ROWS+1) is derived.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: command strobe; honored only in IDLE.
- `base_addr` in AW: address of row 0; sampled on accepted `start`.
- `stride` in AW: address step between rows; sampled on accepted `start`.
- `num_rows` in RW: rows to fetch, 0..MAX_ROWS; sampled on accepted `start`.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: 1-cycle pulse when the command completes.
- `addr_err` out 1: sticky; set on `used_addr` mismatch; cleared on accepted `start`.
- `fetch` out 1: ROM fetch request.
- `addr_use_ext` out 1: constant 1.
- `addr_ext` out AW: ROM start address for the current row.
- `ready` in 1: ROM can accept a fetch.
- `line_valid` in 1: ROM line-return pulse.
- `used_addr` in AW: ROM-reported start address of the returned line.
- `line_in` in DATA_WIDTH x [0:LINE_LEN-1]: returned line.
- `row_valid` out 1: FIFO head valid.
- `row_ready` in 1: downstream accepts the row.
- `row_idx` out RW: row number (0-based) of the head.
- `row_data` out DATA_WIDTH x [0:LINE_LEN-1]: head row words.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- **IDLE**
  - `start` with `num_rows`≠0: latch parameters; set `next_addr`=`base_addr`, issued=0, `addr_err`=0; go to ISSUE.
  - `start` with `num_rows`=0: pulse `done` next cycle; stay in IDLE.
- **ISSUE**
  - `fetch` = 1 iff FIFO count < 2. `addr_ext` = `next_addr`.
  - Accept = `fetch` && `ready`. On accept: issued++, `next_addr` = (`next_addr`+`stride`) mod MEM_DEPTH, go to WAIT.
  - While `fetch`=1 and `ready`=0, hold `fetch` and `addr_ext` stable.
- **WAIT**
  - `fetch`=0. Wait indefinitely for `line_valid`.
  - On `line_valid`: push {`line_in`, issued-1} into the FIFO.
  - If `used_addr` ≠ the address issued for that row, set `addr_err`; the data is still pushed.
  - Next state: DRAIN if issued == `num_rows`, else ISSUE.
- **DRAIN**
  - When the FIFO is empty (including when it empties this cycle through a pop), pulse `done` the next cycle and return to IDLE.
- **Row FIFO**
  - 2 entries, registered.
  - `row_valid` = !empty; `row_data` and `row_idx` show the head.
  - Pop on `row_valid` && `row_ready`. Push and pop in the same cycle are legal.
  - Overflow is impossible: a fetch is issued only when a slot is free, and at most one fetch is outstanding.
- **Ignored inputs**
  - `line_valid` outside WAIT is ignored; no push and no error.
  - `start` while `busy` is ignored.
- **Reset**, asynchronous, including mid-operation:
  - state=IDLE, FIFO empty.
  - `fetch`=0, `addr_ext`=0, `busy`=0, `done`=0, `row_valid`=0, `row_idx`=0, `row_data`=all 0, `addr_err`=0.
  - `addr_use_ext`=1 at all times.

## Timing
- `start` accepted at cycle 0: `busy`=1 and `fetch` may assert at cycle 1.
- With a ROM that has no stall:
  - accept at cycle 1, `line_valid` at 2, `row_valid` at 3.
  - next `fetch` at cycle 3.
  - Steady state: 1 row per 2 cycles plus ROM stall cycles.
- `done` pulses 1 cycle after the last row is popped; `busy` drops in the same cycle as `done`.
- For `num_rows`=0, `done` pulses at cycle 1.
- `fetch` is a registered function of state and FIFO count. It has no combinational path from `ready`.

## Test plan
- **Basic fetch.** Setup: ROM contents rom[k]=k, MAX_STALL=0, `row_ready`=1. Command: `base_addr`=0x10, `stride`=16, `num_rows`=3. Required: rows with `row_idx` 0,1,2, where `row_data`[j] = 0x10+16·idx+j; exactly one `done` pulse; `addr_err`=0.
- **Wrap-around.** Command: `base_addr`=0xF8, `stride`=16, `num_rows`=2. Required: row0 words = 0xF8..0xFF then 0x00..0x07; row1 `addr_ext`=0x08 with words 0x08..0x17.
- **Backpressure.** Setup: `row_ready`=0, `num_rows`=5. Required: after 2 rows are buffered, `fetch` stays 0 and `busy`=1. Then set `row_ready`=1: all 5 rows arrive in index order, and `done` follows the last pop.
- **Random stall.** Setup: MAX_STALL=5, `num_rows`=8, `stride`=3. Required: `addr_ext` is stable throughout every `fetch`&&!`ready` interval; every row matches the ROM; `addr_err`=0. Also inject a corrupted `used_addr` on row 4: `addr_err` sets and stays set until the next `start`.
- **Zero rows and start-while-busy.** `num_rows`=0: `done` at cycle 1 and `fetch` never asserts. A second `start` issued during a busy command has no effect on the row sequence.
- **Mid-operation reset.** Assert `rst` right after the row-1 fetch is accepted. Required: all outputs go to their reset values immediately, and the late `line_valid` causes no push. A new command then completes correctly.
